mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between instruction fetch (IF) and load/store (D) requesters. This lets the CPU move from split combinational memories to one unified memory with stall-capable handshakes.
- Fixed priority favours D. A starvation counter guarantees IF progress.
- At most one read is outstanding. A read timeout recovers from a hung memory.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 4, consecutive D grants while IF_req is high before IF is forced; range 1..15.
- TIMEOUT, 16, maximum cycles spent in WAIT_RESP before an error completion; range 2..255.

Ports:
- SYS_clk  in  1  clock, rising edge.
- SYS_reset_n  in  1  reset, asynchronous, active-low.
- IF_req  in  1  fetch request; held with IF_addr until IF_ready.
- IF_addr  in  ADDR_W  fetch address.
- IF_ready  out  1  fetch accepted this cycle.
- IF_rvalid  out  1  fetch data valid, one-cycle pulse.
- IF_rdata  out  DATA_W  fetch data.
- D_req  in  1  load/store request; held with all D_* inputs until D_ready.
- D_we  in  1  1=store, 0=load.
- D_length  in  2  01=byte, 10=half, 11=word.
- D_signed  in  1  load sign-extend.
- D_addr  in  ADDR_W  data address.
- D_wdata  in  DATA_W  store data.
- D_ready  out  1  D request accepted this cycle.
- D_rvalid  out  1  load data valid, one-cycle pulse.
- D_rdata  out  DATA_W  load data.
- ERR  out  1  one-cycle pulse on read timeout.
- MEM_req  out  1  request to memory.
- MEM_we  out  1  forwarded D_we; 0 for fetch.
- MEM_length  out  2  forwarded; 11 for fetch.
- MEM_signed  out  1  forwarded; 0 for fetch.
- MEM_addr  out  ADDR_W  selected address.
- MEM_wdata  out  DATA_W  forwarded D_wdata; 0 for fetch.
- MEM_ready  in  1  memory accepts MEM_req this cycle.
- MEM_rvalid  in  1  read data valid; reads only.
- MEM_rdata  in  DATA_W  read data.

Behaviour:
- State machine has two states: IDLE and WAIT_RESP.
- Registered state:
  - current state;
  - owner bit (0=IF, 1=D);
  - starve counter, 4 bits;
  - timeout counter, 8 bits.
- Reset (SYS_reset_n=0, asynchronous):
  - state goes to IDLE; owner, starve counter and timeout counter go to 0.
  - All outputs read 0 while reset is asserted and afterwards until a request arrives.
- Reset mid-transaction abandons the transaction. A stale MEM_rvalid arriving later in IDLE is ignored and produces no rvalid.
- Winner selection in IDLE (combinational):
  - D wins if D_req=1, unless IF_req=1 and the starve counter equals STARVE_LIMIT, in which case IF wins.
  - Otherwise IF wins if IF_req=1.
- While a grant exists in IDLE:
  - MEM_req=1 and the MEM_* fields come from the winner.
  - The winner's ready output equals MEM_ready; the loser's ready output is 0.
- With no grant, every MEM_* output is 0.
- Starve counter, updated on accepted requests (MEM_req & MEM_ready):
  - D accepted while IF_req=1: counter increments.
  - IF accepted: counter clears.
  - D accepted while IF_req=0: counter clears.
- Accepted store: complete at acceptance; stay in IDLE; no rvalid is produced. Back-to-back stores may be accepted on consecutive cycles.
- Accepted read (fetch, or D with D_we=0): latch owner, clear the timeout counter, go to WAIT_RESP.
- In WAIT_RESP:
  - MEM_req=0 and both ready outputs are 0.
  - The timeout counter increments each cycle.
  - On MEM_rvalid=1, MEM_rdata passes combinationally to the owner's rdata and the owner's rvalid pulses for that cycle. The state returns to IDLE; the next grant can happen no earlier than the following cycle (a one-cycle bubble).
  - If the timeout counter reaches TIMEOUT-1 with MEM_rvalid=0: the owner's rvalid pulses with rdata=0 and ERR=1 for that cycle, then the state returns to IDLE. A late MEM_rvalid after that is ignored.
  - If MEM_rvalid and the timeout condition fall in the same cycle, MEM_rvalid wins and ERR=0.
- rdata outputs are 0 whenever the corresponding rvalid is 0.
- MEM_rvalid in IDLE is ignored.
- A requester dropping req before ready is a protocol violation. Behaviour in that case is undefined but must not deadlock: with no request the state stays IDLE.

Test Plan:
- Reset: hold SYS_reset_n=0 with IF_req=D_req=1 -> all outputs 0. Release, MEM_ready=1 -> D granted first, MEM_addr=D_addr.
- Fetch round trip: IF_req=1, IF_addr=0x100, memory returns 0x00500093 two cycles after accept -> IF_ready 1 cycle, WAIT_RESP for 2 cycles, IF_rvalid=1 with IF_rdata=0x00500093, next grant no earlier than the following cycle.
- Store pass-through: D_req, D_we=1, D_length=01, D_addr=0x204, D_wdata=0xAB -> MEM_we=1, MEM_length=01, D_ready=1, no D_rvalid. Three consecutive stores are accepted on 3 consecutive cycles.
- Starvation, STARVE_LIMIT=4: IF_req and D_req held high, stores only -> exactly 4 D grants, then an IF grant, then the counter is clear and D is granted again.
- Timeout, TIMEOUT=16: D load accepted and MEM_rvalid never asserted -> D_rvalid=1, D_rdata=0, ERR=1 at cycle 16 after accept. A MEM_rvalid injected at cycle 18 produces no output.
- Reset in WAIT_RESP: assert SYS_reset_n=0 asynchronously mid-read -> state is IDLE immediately, outputs 0. The subsequent MEM_rvalid produces no IF_rvalid or D_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and load/store (D).
// D has fixed priority, a starvation counter forces IF through, and one read may be outstanding, with a timeout.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset_n,
    input  logic              IF_req,
    input  logic [ADDR_W-1:0] IF_addr,
    output logic              IF_ready,
    output logic              IF_rvalid,
    output logic [DATA_W-1:0] IF_rdata,
    input  logic              D_req,
    input  logic              D_we,
    input  logic [1:0]        D_length,
    input  logic              D_signed,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic              D_ready,
    output logic              D_rvalid,
    output logic [DATA_W-1:0] D_rdata,
    output logic              ERR,
    output logic              MEM_req,
    output logic              MEM_we,
    output logic [1:0]        MEM_length,
    output logic              MEM_signed,
    output logic [ADDR_W-1:0] MEM_addr,
    output logic [DATA_W-1:0] MEM_wdata,
    input  logic              MEM_ready,
    input  logic              MEM_rvalid,
    input  logic [DATA_W-1:0] MEM_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic [7:0] tmo_q, tmo_d;

    logic if_starved;
    logic sel_d;
    logic sel_if;
    logic accept;
    logic acc_read;
    logic tmo_hit;

    // Winner selection. Grants are held off while reset is asserted, so that every output reads 0.
    always_comb begin
        if_starved = IF_req && (starve_q == 4'(STARVE_LIMIT));
        sel_d      = 1'b0;
        sel_if     = 1'b0;
        if ((state_q == ST_IDLE) && SYS_reset_n) begin
            sel_d  = D_req && !if_starved;
            sel_if = IF_req && !sel_d;
        end
        accept   = (sel_d || sel_if) && MEM_ready;
        acc_read = accept && (sel_if || !D_we);
        tmo_hit  = (state_q == ST_WAIT) && !MEM_rvalid && (tmo_q == 8'(TIMEOUT - 1));
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
            tmo_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next state: stores complete at acceptance, and reads park in WAIT until data arrives or the timeout expires.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    starve_d = (sel_d && IF_req) ? starve_q + 4'd1 : 4'd0;
                    if (acc_read) begin
                        owner_d = sel_d;
                        tmo_d   = 8'd0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 8'd1;
                if (MEM_rvalid || tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: request mux toward memory, and response steering back to the owner.
    always_comb begin
        MEM_req    = 1'b0;
        MEM_we     = 1'b0;
        MEM_length = 2'b00;
        MEM_signed = 1'b0;
        MEM_addr   = '0;
        MEM_wdata  = '0;
        IF_ready   = 1'b0;
        D_ready    = 1'b0;
        IF_rvalid  = 1'b0;
        IF_rdata   = '0;
        D_rvalid   = 1'b0;
        D_rdata    = '0;
        ERR        = 1'b0;
        if (sel_d) begin
            MEM_req    = 1'b1;
            MEM_we     = D_we;
            MEM_length = D_length;
            MEM_signed = D_signed;
            MEM_addr   = D_addr;
            MEM_wdata  = D_wdata;
            D_ready    = MEM_ready;
        end else if (sel_if) begin
            MEM_req    = 1'b1;
            MEM_length = 2'b11;
            MEM_addr   = IF_addr;
            IF_ready   = MEM_ready;
        end
        if ((state_q == ST_WAIT) && (MEM_rvalid || tmo_hit)) begin
            if (owner_q) begin
                D_rvalid = 1'b1;
                D_rdata  = MEM_rvalid ? MEM_rdata : '0;
            end else begin
                IF_rvalid = 1'b1;
                IF_rdata  = MEM_rvalid ? MEM_rdata : '0;
            end
            ERR = tmo_hit;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SLIM  = 4;
    localparam int unsigned TMO   = 16;
    localparam int unsigned OUT_W = 138;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_length;
    logic          d_signed;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_length;
    logic          mem_signed;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SLIM), .TIMEOUT(TMO)
    ) dut (
        .SYS_clk(clk), .SYS_reset_n(rst_n),
        .IF_req(if_req), .IF_addr(if_addr), .IF_ready(if_ready),
        .IF_rvalid(if_rvalid), .IF_rdata(if_rdata),
        .D_req(d_req), .D_we(d_we), .D_length(d_length), .D_signed(d_signed),
        .D_addr(d_addr), .D_wdata(d_wdata), .D_ready(d_ready),
        .D_rvalid(d_rvalid), .D_rdata(d_rdata), .ERR(err),
        .MEM_req(mem_req), .MEM_we(mem_we), .MEM_length(mem_length),
        .MEM_signed(mem_signed), .MEM_addr(mem_addr), .MEM_wdata(mem_wdata),
        .MEM_ready(mem_ready), .MEM_rvalid(mem_rvalid), .MEM_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] all_outs();
        return {mem_req, mem_we, mem_length, mem_signed, mem_addr, mem_wdata,
                if_ready, d_ready, if_rvalid, if_rdata, d_rvalid, d_rdata, err};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_length = 2'b00; d_signed = 1'b0;
        d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_length = 2'b11; d_addr = 32'h40; d_wdata = 32'h55;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        next_cycle();
        @(negedge clk);
        n_total++;
        if (all_outs() !== '0) $display("FAIL reset_outputs: got %h required 0", all_outs());
        else n_pass++;
        next_cycle();
        if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (all_outs() !== '0) $display("FAIL idle_after_reset: got %h required 0", all_outs());
        else n_pass++;
        next_cycle();
        if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        n_total++;
        if ({mem_req, d_ready, if_ready, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h40})
            $display("FAIL first_grant_d: got req=%b dr=%b ir=%b addr=%h required 1 1 0 00000040",
                     mem_req, d_ready, if_ready, mem_addr);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({mem_req, if_ready, d_ready, mem_length, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h100})
            $display("FAIL fetch_accept: got req=%b ir=%b dr=%b len=%b we=%b addr=%h",
                     mem_req, if_ready, d_ready, mem_length, mem_we, mem_addr);
        else n_pass++;
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_req, if_ready, if_rvalid, if_rdata} !== '0)
            $display("FAIL fetch_wait1: got req=%b ir=%b rv=%b rd=%h required all 0",
                     mem_req, if_ready, if_rvalid, if_rdata);
        else n_pass++;
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        if_req = 1'b1; if_addr = 32'h104;
        @(negedge clk);
        n_total++;
        if ({if_rvalid, if_rdata, if_ready, mem_req, d_rvalid, err} !== {1'b1, 32'h0050_0093, 4'b0000})
            $display("FAIL fetch_data: got rv=%b rd=%h ir=%b req=%b drv=%b err=%b required 1 00500093 0 0 0 0",
                     if_rvalid, if_rdata, if_ready, mem_req, d_rvalid, err);
        else n_pass++;
        next_cycle();
        mem_rvalid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_req, if_ready, mem_addr, if_rvalid} !== {1'b1, 1'b1, 32'h104, 1'b0})
            $display("FAIL fetch_regrant: got req=%b ir=%b addr=%h rv=%b required 1 1 00000104 0",
                     mem_req, if_ready, mem_addr, if_rvalid);
        else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_store();
        logic [70:0] exp_v;
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_length = 2'b01; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_addr  = 32'h204 + 32'(k);
            d_wdata = 32'hAB + 32'(k);
            exp_v   = {1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 32'h204 + 32'(k), 32'hAB + 32'(k)};
            @(negedge clk);
            n_total++;
            if ({mem_req, mem_we, mem_length, d_ready, d_rvalid, mem_addr, mem_wdata} !== exp_v)
                $display("FAIL store_%0d: got %h required %h", k,
                         {mem_req, mem_we, mem_length, d_ready, d_rvalid, mem_addr, mem_wdata}, exp_v);
            else n_pass++;
            next_cycle();
        end
        d_req = 1'b0;
        @(negedge clk);
        n_total++;
        if ({d_rvalid, mem_req} !== 2'b00) $display("FAIL store_no_rvalid: got rv=%b req=%b", d_rvalid, mem_req);
        else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_starve();
        logic [1:0] exp_seq [7];
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b10};
        do_reset();
        if_req = 1'b1; if_addr = 32'h600;
        d_req = 1'b1; d_we = 1'b1; d_length = 2'b11; d_addr = 32'h700; mem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            mem_rvalid = (k == 5);
            mem_rdata  = 32'h1111_0000 + 32'(k);
            @(negedge clk);
            n_total++;
            if ({d_ready, if_ready} !== exp_seq[k])
                $display("FAIL starve_cycle_%0d: got d/if ready=%b%b required %b", k, d_ready, if_ready, exp_seq[k]);
            else n_pass++;
            if (k == 5) begin
                n_total++;
                if ({if_rvalid, if_rdata} !== {1'b1, 32'h1111_0005})
                    $display("FAIL starve_fetch_data: got rv=%b rd=%h required 1 11110005", if_rvalid, if_rdata);
                else n_pass++;
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_length = 2'b11; d_addr = 32'h300; mem_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (d_ready !== 1'b1) $display("FAIL load_accept: got %b required 1", d_ready);
        else n_pass++;
        next_cycle();
        d_req = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            n_total++;
            if ({d_rvalid, if_rvalid, err} !== 3'b000)
                $display("FAIL timeout_early_%0d: got drv/irv/err=%b%b%b required 000", k, d_rvalid, if_rvalid, err);
            else n_pass++;
            next_cycle();
        end
        @(negedge clk);
        n_total++;
        if ({d_rvalid, d_rdata, err, if_rvalid} !== {1'b1, 32'h0, 1'b1, 1'b0})
            $display("FAIL timeout_err: got drv=%b drd=%h err=%b irv=%b required 1 00000000 1 0",
                     d_rvalid, d_rdata, err, if_rvalid);
        else n_pass++;
        next_cycle();
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_total++;
        if ({d_rvalid, if_rvalid, err, d_rdata, if_rdata} !== '0)
            $display("FAIL late_rvalid: got drv=%b irv=%b err=%b drd=%h ird=%h required all 0",
                     d_rvalid, if_rvalid, err, d_rdata, if_rdata);
        else n_pass++;
        next_cycle();
        mem_rvalid = 1'b0;
        d_req = 1'b1;
        @(negedge clk);
        next_cycle();
        d_req = 1'b0;
        for (int k = 1; k < 16; k++) next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        n_total++;
        if ({d_rvalid, d_rdata, err} !== {1'b1, 32'hCAFE_0001, 1'b0})
            $display("FAIL rvalid_beats_timeout: got drv=%b drd=%h err=%b required 1 cafe0001 0",
                     d_rvalid, d_rdata, err);
        else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1'b1; if_addr = 32'h500; mem_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (if_ready !== 1'b1) $display("FAIL midreset_accept: got %b required 1", if_ready);
        else n_pass++;
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (all_outs() !== '0) $display("FAIL midreset_outputs: got %h required 0", all_outs());
        else n_pass++;
        next_cycle();
        rst_n = 1'b1; if_req = 1'b0;
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_total++;
        if ({if_rvalid, d_rvalid, err} !== 3'b000)
            $display("FAIL midreset_stale: got irv/drv/err=%b%b%b required 000", if_rvalid, d_rvalid, err);
        else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    // Transaction-level model: an arbitration decision per cycle, a busy flag, and the count of cycles elapsed since acceptance.
    task automatic test_random();
        bit busy = 0;
        bit owner_d = 0;
        int elapsed = 0;
        int lat = 0;
        int starve = 0;
        bit if_pend = 0;
        bit d_pend = 0;
        bit take_d, take_if, done;
        logic [OUT_W-1:0] exp_v;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_ifd, e_dd;
        logic e_mreq, e_we, e_sg, e_ifr, e_dr, e_ifv, e_dv, e_err;
        logic [1:0] e_len;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_length = 2'($urandom_range(1, 3));
                d_signed = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end
            if_req = if_pend;
            d_req = d_pend;
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = $urandom;
            mem_rvalid = busy ? (elapsed == lat) : ($urandom_range(0, 19) == 0);
            @(negedge clk);
            e_mreq = 0; e_we = 0; e_len = 2'b00; e_sg = 0; e_addr = '0; e_wd = '0;
            e_ifr = 0; e_dr = 0; e_ifv = 0; e_ifd = '0; e_dv = 0; e_dd = '0; e_err = 0;
            take_d = 0; take_if = 0;
            if (!busy) begin
                if (d_req && !(if_req && starve == int'(SLIM))) take_d = 1;
                else if (if_req) take_if = 1;
            end
            if (take_d) begin
                e_mreq = 1; e_we = d_we; e_len = d_length; e_sg = d_signed;
                e_addr = d_addr; e_wd = d_wdata; e_dr = mem_ready;
            end else if (take_if) begin
                e_mreq = 1; e_len = 2'b11; e_addr = if_addr; e_ifr = mem_ready;
            end
            done = busy && (mem_rvalid || elapsed == int'(TMO));
            if (done) begin
                if (owner_d) begin e_dv = 1; e_dd = mem_rvalid ? mem_rdata : '0; end
                else begin e_ifv = 1; e_ifd = mem_rvalid ? mem_rdata : '0; end
                e_err = !mem_rvalid;
            end
            exp_v = {e_mreq, e_we, e_len, e_sg, e_addr, e_wd, e_ifr, e_dr, e_ifv, e_ifd, e_dv, e_dd, e_err};
            n_total++;
            if (all_outs() !== exp_v) $display("FAIL random_cycle_%0d: got %h required %h", c, all_outs(), exp_v);
            else n_pass++;
            if (busy) begin
                if (done) busy = 0;
                else elapsed++;
            end else if (mem_ready && (take_d || take_if)) begin
                starve = (take_d && if_req) ? starve + 1 : 0;
                if (take_d) d_pend = 0;
                else if_pend = 0;
                if (take_if || !d_we) begin
                    busy = 1; owner_d = take_d; elapsed = 1; lat = $urandom_range(1, 20);
                end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_fetch();
        test_store();
        test_starve();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
